// File: rtl/hermes_pkg.sv
//------------------------------------------------------------------------------
// Module      : hermes_pkg
// Description : Shared Hermes NoC constants, NI transmitter state type and the
//               header flit builder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hermes_pkg;

    localparam int FLIT_WIDTH = 16;
    localparam int ADDR_W     = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        SIZE    = 2'd2,
        PAYLOAD = 2'd3
    } ni_tx_state_t;

    // Header flit carries the XY router address in its low byte.
    function automatic logic [FLIT_WIDTH-1:0] hdr_flit(input logic [ADDR_W-1:0] target);
        return {{(FLIT_WIDTH-ADDR_W){1'b0}}, target};
    endfunction

endpackage

`default_nettype wire

// File: rtl/hermes_ni_tx_if.sv
//------------------------------------------------------------------------------
// Module      : hermes_ni_tx_if
// Description : Command, payload and router-side signals of the NI transmitter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hermes_ni_tx_if #(
    parameter int SIZE_W = 16
);
    import hermes_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_W-1:0]     cmd_target;
    logic [SIZE_W-1:0]     cmd_size;
    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_WIDTH-1:0] in_data;
    logic                  tx_avail;
    logic [FLIT_WIDTH-1:0] tx_data;
    logic                  tx_credit;
    logic                  busy;
    logic                  pkt_done;

    // master = local core / router model, slave = the NI transmitter
    modport master (
        output cmd_valid, cmd_target, cmd_size, in_valid, in_data, tx_credit,
        input  cmd_ready, in_ready, tx_avail, tx_data, busy, pkt_done
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_size, in_valid, in_data, tx_credit,
        output cmd_ready, in_ready, tx_avail, tx_data, busy, pkt_done
    );

endinterface

`default_nettype wire

// File: rtl/hermes_flit_fifo.sv
//------------------------------------------------------------------------------
// Module      : hermes_flit_fifo
// Description : Synchronous flit FIFO with registered pointers and head read
//               directly from storage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hermes_flit_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic      [WIDTH-1:0] o_head
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/hermes_ni_tx.sv
//------------------------------------------------------------------------------
// Module      : hermes_ni_tx
// Description : Hermes local-port NI transmitter; serialises header, size and
//               buffered payload flits under credit-based flow control.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hermes_ni_tx
    import hermes_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int SIZE_W = 16
) (
    input  wire logic     clock,
    input  wire logic     reset,
    hermes_ni_tx_if.slave bus
);

    localparam logic [SIZE_W-1:0] c_SIZE_ONE = SIZE_W'(1);

    ni_tx_state_t          r_state;
    logic [ADDR_W-1:0]     r_target;
    logic [SIZE_W-1:0]     r_size;
    logic [SIZE_W-1:0]     r_remaining;
    logic                  r_pkt_done;
    logic                  r_cmd_ready;
    logic                  r_live;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [FLIT_WIDTH-1:0] w_fifo_head;
    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_xfer;
    logic                  w_tx_avail;
    logic [FLIT_WIDTH-1:0] w_tx_data;

    // r_live keeps in_ready low while reset is held.
    assign w_in_ready = r_live && !w_fifo_full;
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_xfer     = w_tx_avail && bus.tx_credit;
    assign w_pop      = w_xfer && (r_state == PAYLOAD);

    hermes_flit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_WIDTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (bus.in_data),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    // Output flit is a function of registered state only, never of tx_credit.
    always_comb begin
        w_tx_avail = 1'b0;
        w_tx_data  = '0;
        case (r_state)
            HEADER: begin
                w_tx_avail = 1'b1;
                w_tx_data  = hdr_flit(r_target);
            end
            SIZE: begin
                w_tx_avail = 1'b1;
                w_tx_data  = FLIT_WIDTH'(r_size);
            end
            PAYLOAD: begin
                w_tx_avail = !w_fifo_empty;
                w_tx_data  = w_fifo_head;
            end
            default: begin
                w_tx_avail = 1'b0;
                w_tx_data  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_target    <= '0;
            r_size      <= '0;
            r_remaining <= '0;
            r_pkt_done  <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_live      <= 1'b0;
        end else begin
            r_live     <= 1'b1;
            r_pkt_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_target    <= bus.cmd_target;
                        r_size      <= bus.cmd_size;
                        r_cmd_ready <= 1'b0;
                        r_state     <= HEADER;
                    end
                end
                HEADER: begin
                    if (w_xfer) r_state <= SIZE;
                end
                SIZE: begin
                    if (w_xfer) begin
                        if (r_size == '0) begin
                            r_state     <= IDLE;
                            r_pkt_done  <= 1'b1;
                            r_cmd_ready <= 1'b1;
                        end else begin
                            r_remaining <= r_size;
                            r_state     <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_xfer) begin
                        r_remaining <= r_remaining - c_SIZE_ONE;
                        if (r_remaining == c_SIZE_ONE) begin
                            r_state     <= IDLE;
                            r_pkt_done  <= 1'b1;
                            r_cmd_ready <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.tx_avail  = w_tx_avail;
    assign bus.tx_data   = w_tx_data;
    assign bus.busy      = (r_state != IDLE);
    assign bus.pkt_done  = r_pkt_done;

endmodule

`default_nettype wire

// File: tb/tb_hermes_ni_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_hermes_ni_tx
// Description : Scoreboard bench for hermes_ni_tx.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hermes_ni_tx;
    import hermes_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hermes_ni_tx_if #(.SIZE_W(16)) bus ();

    hermes_ni_tx #(
        .DEPTH  (16),
        .SIZE_W (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] mdl_q [$];
    int          need_pl = 0;
    int          xfer_cyc [$];
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        tog_en = 1'b0;
    int          tog_k = 0;
    logic [3:0]  pat = 4'b1001;
    int          cmd_cyc = 0;
    int          push_cyc = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: every transfer is scored, stalled flits must hold steady.
    always @(negedge clock) begin
        if (!reset) begin
            if (prev_stall && bus.tx_avail) check("stall_hold", bus.tx_data, prev_data);
            if (bus.tx_avail && bus.tx_credit) begin
                xfer_cnt++;
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("sb_unexpected_flit", exp_q.size(), 1);
                else                   check("flit", bus.tx_data, exp_q.pop_front());
            end
            if (bus.pkt_done) begin
                done_cnt++;
                done_cyc   = cyc;
                done_ready = bus.cmd_ready;
            end
        end
        prev_stall = !reset && bus.tx_avail && !bus.tx_credit;
        prev_data  = bus.tx_data;
    end

    always @(posedge clock) begin
        if (tog_en) begin
            #1;
            bus.tx_credit = pat[tog_k % 4];
            tog_k++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        while (need_pl > 0 && mdl_q.size() > 0) begin
            exp_q.push_back(mdl_q.pop_front());
            need_pl--;
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (bus.in_ready) ok = 1'b1;
            else              tick();
        end
        if (!ok) check("push_timeout", ok, 1);
        tick();
        bus.in_valid = 1'b0;
        push_cyc = cyc;
        if (ok) begin
            mdl_q.push_back(w);
            settle();
        end
    endtask

    task automatic send_cmd(input logic [7:0] t, input logic [15:0] s);
        bit ok = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = t;
        bus.cmd_size   = s;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (bus.cmd_ready) ok = 1'b1;
            else               tick();
        end
        tick();
        bus.cmd_valid = 1'b0;
        cmd_cyc = cyc;
        if (!ok) check("cmd_timeout", ok, 1);
        else begin
            exp_q.push_back(hdr_flit(t));
            exp_q.push_back(s);
            need_pl += int'(s);
            settle();
        end
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        for (int k = 0; k < budget && done_cnt == start; k++) tick();
        check("pkt_done_seen", done_cnt, start + 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.cmd_valid  = 1'b0;
        bus.cmd_target = '0;
        bus.cmd_size   = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.tx_credit  = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_in_ready",  bus.in_ready, 0);
        check("rst_tx_avail",  bus.tx_avail, 0);
        check("rst_tx_data",   bus.tx_data, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_pkt_done",  bus.pkt_done, 0);
        reset = 1'b0;
        tick();
        check("post_rst_cmd_ready", bus.cmd_ready, 1);
        check("post_rst_in_ready",  bus.in_ready, 1);
        check("post_rst_tx_avail",  bus.tx_avail, 0);

        // Basic packet with pre-loaded payload, back-to-back timing
        for (int i = 1; i <= 3; i++) push_word(16'hA000 + 16'(i));
        xfer_cyc.delete();
        send_cmd(8'h11, 16'd3);
        wait_done(30);
        check("t1_nxfer", xfer_cyc.size(), 5);
        for (int i = 0; i < xfer_cyc.size() && i < 5; i++)
            check("t1_xfer_cycle", xfer_cyc[i] - cmd_cyc, i);
        check("t1_done_cycle", done_cyc - cmd_cyc, 5);
        check("t1_done_cmd_ready", done_ready, 1);
        check("t1_sb_drained", exp_q.size(), 0);

        // Zero-size packet must leave queued payload untouched
        push_word(16'hB001);
        push_word(16'hB002);
        xfer_cyc.delete();
        send_cmd(8'h20, 16'd0);
        wait_done(30);
        check("t2_nxfer", xfer_cyc.size(), 2);
        check("t2_done_cycle", done_cyc - cmd_cyc, 2);
        send_cmd(8'h21, 16'd2);
        wait_done(30);
        check("t2_sb_drained", exp_q.size(), 0);

        // Credit toggling 1,0,0,1 during a size=4 packet
        for (int i = 0; i < 4; i++) push_word(16'hC000 + 16'(i));
        base  = xfer_cnt;
        tog_k = 0;
        tog_en = 1'b1;
        send_cmd(8'h32, 16'd4);
        wait_done(80);
        tog_en = 1'b0;
        tick();
        bus.tx_credit = 1'b1;
        check("t3_transfers", xfer_cnt - base, 6);
        check("t3_sb_drained", exp_q.size(), 0);

        // Command before payload
        xfer_cyc.delete();
        send_cmd(8'h33, 16'd2);
        repeat (5) tick();
        check("t4_avail_starved", bus.tx_avail, 0);
        check("t4_busy", bus.busy, 1);
        push_word(16'hD001);
        base = push_cyc;
        push_word(16'hD002);
        wait_done(30);
        check("t4_nxfer", xfer_cyc.size(), 4);
        if (xfer_cyc.size() == 4) begin
            check("t4_word1_latency", xfer_cyc[2] - base, 0);
            check("t4_word2_latency", xfer_cyc[3] - push_cyc, 0);
        end

        // Fill to DEPTH, overflow attempt, drain, then wrap with a second fill
        for (int i = 0; i < 16; i++) push_word(16'hE000 + 16'(i));
        check("t5_full_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hDEAD;
        tick();
        bus.in_valid = 1'b0;
        check("t5_still_full", bus.in_ready, 0);
        send_cmd(8'h44, 16'd16);
        wait_done(60);
        check("t5_sb_drained", exp_q.size(), 0);
        check("t5_in_ready_after", bus.in_ready, 1);
        for (int i = 0; i < 16; i++) push_word(16'hF000 + 16'(i));
        check("t5_refull_in_ready", bus.in_ready, 0);
        send_cmd(8'h45, 16'd16);
        wait_done(60);
        check("t5_wrap_sb_drained", exp_q.size(), 0);

        // Reset in the middle of a size=5 packet
        for (int i = 1; i <= 5; i++) push_word(16'h6000 + 16'(i));
        base = xfer_cnt;
        send_cmd(8'h46, 16'd5);
        for (int k = 0; k < 30 && xfer_cnt < base + 4; k++) tick();
        check("t6_reached_two_payload", xfer_cnt - base, 4);
        reset = 1'b1;
        exp_q.delete();
        mdl_q.delete();
        need_pl = 0;
        tick();
        check("t6_rst_tx_avail", bus.tx_avail, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_in_ready", bus.in_ready, 0);
        reset = 1'b0;
        tick();
        check("t6_post_tx_avail", bus.tx_avail, 0);
        check("t6_post_busy", bus.busy, 0);
        check("t6_post_cmd_ready", bus.cmd_ready, 1);
        push_word(16'h7001);
        xfer_cyc.delete();
        send_cmd(8'h47, 16'd1);
        wait_done(30);
        check("t6_nxfer", xfer_cyc.size(), 3);
        check("t6_sb_drained", exp_q.size(), 0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
